// File: rtl/lfsr_word_packer_if.sv
// rtl/lfsr_word_packer_if.sv - serial-bit in / packed-word out bundle for lfsr_word_packer
interface lfsr_word_packer_if #(
    parameter int WIDTH = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic [4:0]       lfsr_state;
    logic             flush;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             lock_err;
    logic [15:0]      word_count;

    modport slave (
        input  bit_in, bit_valid, lfsr_state, flush, word_ready,
        output bit_ready, word_out, word_valid, lock_err, word_count
    );

    modport master (
        output bit_in, bit_valid, lfsr_state, flush, word_ready,
        input  bit_ready, word_out, word_valid, lock_err, word_count
    );
endinterface

// File: rtl/lfsr_word_packer.sv
// rtl/lfsr_word_packer.sv - packs LFSR serial bits LSB-first into words behind a 2-entry FIFO
module lfsr_word_packer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_word_packer_if.slave  bus
);
    localparam int IDXW = $clog2(WIDTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    logic [IDXW-1:0]  r_bit_idx;
    logic [WIDTH-1:0] r_partial;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             r_lock_err;
    logic [15:0]      r_word_count;

    logic             w_bit_ready;
    logic             w_accept;
    logic             w_complete;
    logic             w_pop;
    logic [WIDTH-1:0] w_word;

    // Only the word-completing bit can overflow the FIFO, so only that one is stalled.
    assign w_bit_ready = (r_count != 2'd2) || (r_bit_idx != LAST_IDX);
    assign w_accept    = bus.bit_valid && w_bit_ready && !bus.flush;
    assign w_complete  = w_accept && (r_bit_idx == LAST_IDX);
    assign w_pop       = (r_count != 2'd0) && bus.word_ready;
    assign w_word      = {bus.bit_in, r_partial[WIDTH-2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_idx <= '0;
            r_partial <= '0;
        end else if (bus.flush) begin
            r_bit_idx <= '0;
            r_partial <= '0;
        end else if (w_complete) begin
            r_bit_idx <= '0;
            r_partial <= '0;
        end else if (w_accept) begin
            r_bit_idx            <= r_bit_idx + IDXW'(1);
            r_partial[r_bit_idx] <= bus.bit_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_err <= 1'b0;
        end else if (bus.flush) begin
            r_lock_err <= 1'b0;
        end else if (w_accept && (bus.lfsr_state == 5'b00000)) begin
            r_lock_err <= 1'b1;
        end
    end

    // r_head is the registered word_out; r_tail holds the second entry when count is 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_complete, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= w_word;
                    else                 r_tail <= w_word;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) r_head <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= w_word;
                    end else begin
                        r_head <= w_word;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_count <= 16'd0;
        end else if (w_pop && (r_word_count != 16'hFFFF)) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end

    assign bus.bit_ready  = w_bit_ready;
    assign bus.word_out   = r_head;
    assign bus.word_valid = (r_count != 2'd0);
    assign bus.lock_err   = r_lock_err;
    assign bus.word_count = r_word_count;
endmodule

// File: doc/lfsr_word_packer.md
LFSR_WORD_PACKER -- requirements
Module: lfsr_word_packer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of serial bits per output word (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port bit_in, input, 1 bit: serial bit from the LFSR output.
REQ-005 The block SHALL have port bit_valid, input, 1 bit: bit_in is valid this cycle; wired in parallel with the LFSR advance.
REQ-006 The block SHALL have port bit_ready, output, 1 bit: packer accepts bit_in this cycle; gates the LFSR advance upstream.
REQ-007 The block SHALL have port lfsr_state, input, 5 bits: current LFSR state vector, used for lock-up detection.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous discard of the partial word; pulsed together with the LFSR reinit.
REQ-009 The block SHALL have port word_out, output, WIDTH bits: head word of the output queue.
REQ-010 The block SHALL have port word_valid, output, 1 bit: word_out holds a valid word.
REQ-011 The block SHALL have port word_ready, input, 1 bit: consumer takes word_out this cycle.
REQ-012 The block SHALL have port lock_err, output, 1 bit: sticky flag, LFSR observed in the all-zero state.
REQ-013 The block SHALL have port word_count, output, 16 bits: saturating count of words delivered to the consumer.

Function
REQ-014 The block SHALL accept a bit when bit_valid=1, bit_ready=1 and flush=0.
REQ-015 The block SHALL pack accepted bits LSB-first: the first accepted bit of a word goes to bit 0, and the n-th accepted bit goes to bit n-1.
REQ-016 The block SHALL track fill position with a bit index counter (0..WIDTH-1); the counter increments on each accept and wraps to 0 on the accept that completes a word.
REQ-017 The block SHALL, on the completing (WIDTH-th) accept, push the assembled word into a 2-entry FIFO; word_valid SHALL be visible on the next rising edge (latency 1 cycle from last bit).
REQ-018 The block SHALL drive bit_ready = (FIFO count < 2) OR (bit index != WIDTH-1); partial bits keep accumulating while the FIFO is full, and only the completing bit is stalled.
REQ-019 The block SHALL compute bit_ready from registered state only, with no combinational path from word_ready or bit_valid.
REQ-020 The block SHALL pop the FIFO when word_valid=1 and word_ready=1; word_out SHALL then present the next entry, or word_valid SHALL drop if the FIFO becomes empty.
REQ-021 The block SHALL leave the FIFO count unchanged on a simultaneous push and pop; a push into a full FIFO cannot occur by construction (REQ-018).
REQ-022 The block SHALL hold word_out stable while word_valid=1 and word_ready=0.
REQ-023 The block SHALL give flush priority over bit acceptance: on flush, clear the bit index and the partial word, clear lock_err, and discard any bit presented that cycle.
REQ-024 The block SHALL preserve FIFO contents and word_count across a flush.
REQ-025 The block SHALL set lock_err when a bit is accepted while lfsr_state == 5'b00000; lock_err SHALL remain set until flush or reset.
REQ-026 The block SHALL increment word_count on each pop and hold it at 16'hFFFF once reached (no wrap).
REQ-027 The block SHALL hold every output, FIFO entry, counter and flag unchanged when bit_valid=0, word_ready=0 and flush=0.

Reset
REQ-028 The block SHALL, while rst=0 (asynchronously, regardless of clk), clear the bit index, partial word, FIFO count, word_out, word_count and lock_err, and drive word_valid=0.
REQ-029 The block SHALL drive bit_ready=1 from reset deassertion onward, and SHALL accept the first bit on the first clk edge with rst=1, bit_valid=1.
REQ-030 The block SHALL, on reset asserted mid-word or mid-transfer, discard all partial and queued words.

Verification
REQ-031 The bench SHALL cover this single word: WIDTH=8; bits 1,0,1,1,0,0,1,0 on consecutive cycles with word_ready=1 -> word_valid for one cycle, 1 cycle after the 8th bit, word_out=8'h4D, word_count=1.
REQ-032 The bench SHALL cover backpressure: word_ready=0, 24 bits streamed -> two words queued; bit_ready drops only when the 24th bit is pending (index=7, count=2); raising word_ready drains 2 words, then the 3rd word is pushed.
REQ-033 The bench SHALL cover flush mid-word: 3 bits accepted, then flush with bit_valid=1 -> that bit is discarded; the next 8 bits form a fresh word; the previously queued word is delivered unchanged.
REQ-034 The bench SHALL cover lock-up: lfsr_state=5'b00000 during one accepted bit -> lock_err=1 next cycle and held for 100 cycles; flush -> lock_err=0.
REQ-035 The bench SHALL cover async reset: rst pulled low between clk edges with count=2 and index=5 -> word_valid=0, word_count=0 immediately; bit_ready=1 after release.
REQ-036 The bench SHALL cover saturation: word_count preloaded to 16'hFFFE via traffic, 3 more pops -> word_count stays 16'hFFFF.
